// File: rtl/scaler_pkg.sv
`timescale 1ns/1ps
// Shared parameter defaults and helpers for the scaler bank.
package scaler_pkg;
  localparam int NCHAN_DEF          = 16;
  localparam int WIDTH_DEF          = 16;
  localparam int PRESCALE_DEF       = 0;
  localparam int REFRESH_CYCLES_DEF = 0;
  localparam int AW_DEF             = 6;
  localparam int SEQ_W              = 8;

  typedef logic [SEQ_W-1:0] seq_t;

  // Ceiling log2, never less than 1 so it can size a register directly.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/scaler_channel.sv
`timescale 1ns/1ps
// One scaler channel: edge detect, saturating counter with sticky
// saturation flag, and the snapshot register latched on refresh.
module scaler_channel import scaler_pkg::*; #(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             count_i,
  input  logic             gate_i,
  input  logic             edge_mode_i,
  input  logic             refresh_i,
  output logic [WIDTH-1:0] snap_o,
  output logic             snap_sat_o
);
  localparam int CW = WIDTH + PRESCALE;

  logic             r_count_d;
  logic [CW-1:0]    r_cnt;
  logic             r_sat;
  logic [WIDTH-1:0] r_snap;
  logic             r_snap_sat;
  logic             w_ev;
  logic             w_full;

  assign w_ev   = gate_i & (edge_mode_i ? (count_i & ~r_count_d) : count_i);
  assign w_full = &r_cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; the snapshot registers are reset too
  // because a cleared bank is part of the visible reset state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count_d  <= 1'b0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_snap     <= '0;
      r_snap_sat <= 1'b0;
    end else begin
      r_count_d <= count_i;
      if (refresh_i) begin
        r_snap     <= r_cnt[PRESCALE +: WIDTH];
        r_snap_sat <= r_sat;
        // A coincident event opens the new interval instead of being lost.
        r_cnt      <= CW'(w_ev);
        r_sat      <= 1'b0;
      end else if (w_ev) begin
        if (w_full) r_sat <= 1'b1;
        else        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign snap_o     = r_snap;
  assign snap_sat_o = r_snap_sat;
endmodule

// File: rtl/scaler_bank.sv
`timescale 1ns/1ps
// Multi-channel scaler bank: per-channel saturating counters snapshotted
// coherently on each refresh, read back through a registered address port.
module scaler_bank import scaler_pkg::*; #(
  parameter int NCHAN          = NCHAN_DEF,
  parameter int WIDTH          = WIDTH_DEF,
  parameter int PRESCALE       = PRESCALE_DEF,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int AW             = AW_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCHAN-1:0] count_i,
  input  logic             gate_i,
  input  logic             edge_mode_i,
  input  logic             refresh_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] scaler_o,
  output logic             sat_o,
  output logic             valid_o,
  output logic [SEQ_W-1:0] seq_o
);
  localparam int NSLOT = 2 ** AW;

  logic             w_tick;
  logic             w_refresh;
  logic [WIDTH-1:0] w_snap     [NSLOT];
  logic             w_snap_sat [NSLOT];
  logic             r_valid;
  seq_t             r_seq;
  logic [WIDTH-1:0] r_scaler;
  logic             r_sat;

  if (REFRESH_CYCLES > 0) begin : g_timer
    localparam int TW = clog2(REFRESH_CYCLES);
    logic [TW-1:0] r_timer;

    assign w_tick = (r_timer == TW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      r_timer <= '0;
      else if (w_tick) r_timer <= '0;
      else             r_timer <= r_timer + 1'b1;
    end
  end else begin : g_no_timer
    assign w_tick = 1'b0;
  end

  assign w_refresh = refresh_i | w_tick;

  // Address slots past NCHAN are tied to zero so out-of-range reads return 0
  // without a separate range compare on the read path.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NCHAN) begin : g_live
      scaler_channel #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
      ) u_channel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .count_i     (count_i[i]),
        .gate_i      (gate_i),
        .edge_mode_i (edge_mode_i),
        .refresh_i   (w_refresh),
        .snap_o      (w_snap[i]),
        .snap_sat_o  (w_snap_sat[i])
      );
    end else begin : g_pad
      assign w_snap[i]     = '0;
      assign w_snap_sat[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid  <= 1'b0;
      r_seq    <= '0;
      r_scaler <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_valid  <= w_refresh;
      if (w_refresh) r_seq <= r_seq + 1'b1;
      r_scaler <= w_snap[rd_addr_i];
      r_sat    <= w_snap_sat[rd_addr_i];
    end
  end

  assign scaler_o = r_scaler;
  assign sat_o    = r_sat;
  assign valid_o  = r_valid;
  assign seq_o    = r_seq;
endmodule

// File: tb/tb_scaler_bank.sv
`timescale 1ns/1ps
// Bench for scaler_bank: three configurations driven by directed tables,
// hand-written corner sequences and a randomized high-level model.
module tb_scaler_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, gate, edge_mode;

  // A: 4 channels, 16 bit, no prescale, external refresh, 3-bit address
  logic [3:0]  count_a;
  logic        refresh_a;
  logic [2:0]  addr_a;
  logic [15:0] scaler_a;
  logic        sat_a, valid_a;
  logic [7:0]  seq_a;
  // B: 2 channels, 4 bit, prescale 2
  logic [1:0]  count_b;
  logic        refresh_b;
  logic [0:0]  addr_b;
  logic [3:0]  scaler_b;
  logic        sat_b, valid_b;
  logic [7:0]  seq_b;
  // C: 4 channels, internal timer of 100 cycles
  logic [3:0]  count_c;
  logic        refresh_c;
  logic [1:0]  addr_c;
  logic [15:0] scaler_c;
  logic        sat_c, valid_c;
  logic [7:0]  seq_c;

  scaler_bank #(.NCHAN(4), .WIDTH(16), .PRESCALE(0), .REFRESH_CYCLES(0), .AW(3)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .count_i(count_a), .gate_i(gate), .edge_mode_i(edge_mode),
    .refresh_i(refresh_a), .rd_addr_i(addr_a), .scaler_o(scaler_a), .sat_o(sat_a),
    .valid_o(valid_a), .seq_o(seq_a));

  scaler_bank #(.NCHAN(2), .WIDTH(4), .PRESCALE(2), .REFRESH_CYCLES(0), .AW(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .count_i(count_b), .gate_i(gate), .edge_mode_i(edge_mode),
    .refresh_i(refresh_b), .rd_addr_i(addr_b), .scaler_o(scaler_b), .sat_o(sat_b),
    .valid_o(valid_b), .seq_o(seq_b));

  scaler_bank #(.NCHAN(4), .WIDTH(16), .PRESCALE(0), .REFRESH_CYCLES(100), .AW(2)) u_dut_c (
    .clk_i(clk), .rst_i(rst_n), .count_i(count_c), .gate_i(gate), .edge_mode_i(edge_mode),
    .refresh_i(refresh_c), .rd_addr_i(addr_c), .scaler_o(scaler_c), .sat_o(sat_c),
    .valid_o(valid_c), .seq_o(seq_c));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    count_a = '0; count_b = '0; count_c = '0;
    refresh_a = 1'b0; refresh_b = 1'b0; refresh_c = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0;
    gate = 1'b1; edge_mode = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_refresh_a();
    refresh_a = 1'b1;
    step();
    refresh_a = 1'b0;
  endtask

  task automatic read_a(input int addr, output logic [15:0] v, output logic s);
    addr_a = 3'(addr);
    step();
    v = scaler_a;
    s = sat_a;
  endtask

  task automatic wait_valid_c(input string name, output int cyc);
    cyc = 0;
    while (!valid_c && cyc < 300) begin
      step();
      cyc++;
    end
    check({name, " arrived"}, 32'(valid_c), 1);
  endtask

  typedef struct {
    int ch;
    bit toggle;
    bit edge_m;
    int ncyc;
    int expv;
  } vec_t;

  // Reference model state: plain event counts per interval, no width limits.
  int   ca [4];
  bit   pa [4];
  int   sva[4];
  bit   ssa[4];
  int   cb [2];
  bit   pb [2];
  int   svb[2];
  bit   ssb[2];
  logic [7:0] seq_m;

  initial begin
    vec_t        vecs[5];
    logic [15:0] v;
    logic        s;
    int          cyc, extra;
    int          exp_va, exp_vb;
    bit          exp_sa, exp_sb, refr, ev;

    vecs[0] = '{ch: 0, toggle: 1'b0, edge_m: 1'b0, ncyc: 10, expv: 10};
    vecs[1] = '{ch: 1, toggle: 1'b1, edge_m: 1'b1, ncyc: 20, expv: 10};
    vecs[2] = '{ch: 1, toggle: 1'b1, edge_m: 1'b0, ncyc: 20, expv: 10};
    vecs[3] = '{ch: 1, toggle: 1'b0, edge_m: 1'b1, ncyc: 10, expv: 1};
    vecs[4] = '{ch: 2, toggle: 1'b1, edge_m: 1'b1, ncyc: 7,  expv: 4};

    // Reset state, observed asynchronously before any clock edge matters
    rst_n = 1'b0;
    count_a = '0; count_b = '0; count_c = '0;
    refresh_a = 1'b0; refresh_b = 1'b0; refresh_c = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0;
    gate = 1'b1; edge_mode = 1'b0;
    #1;
    check("reset scaler_a", 32'(scaler_a), 0);
    check("reset sat_a", 32'(sat_a), 0);
    check("reset valid_a", 32'(valid_a), 0);
    check("reset seq_a", 32'(seq_a), 0);
    check("reset scaler_b", 32'(scaler_b), 0);
    check("reset valid_c", 32'(valid_c), 0);
    check("reset seq_c", 32'(seq_c), 0);

    // Level/edge counting table on A
    do_reset();
    for (int k = 0; k < 5; k++) begin
      edge_mode = vecs[k].edge_m;
      for (int c = 0; c < vecs[k].ncyc; c++) begin
        count_a = '0;
        count_a[vecs[k].ch] = vecs[k].toggle ? (c % 2 == 0) : 1'b1;
        step();
      end
      count_a = '0;
      pulse_refresh_a();
      check($sformatf("vec%0d valid", k), 32'(valid_a), 1);
      check($sformatf("vec%0d seq", k), 32'(seq_a), 32'(k + 1));
      for (int a = 0; a < 5; a++) begin
        read_a(a, v, s);
        if (a == 0) check($sformatf("vec%0d valid one cycle", k), 32'(valid_a), 0);
        check($sformatf("vec%0d ch%0d value", k, a), 32'(v),
              (a == vecs[k].ch) ? 32'(vecs[k].expv) : 32'd0);
        check($sformatf("vec%0d ch%0d sat", k, a), 32'(s), 0);
      end
    end

    // Event coincident with refresh after 7 prior events lands in new interval
    edge_mode = 1'b0;
    count_a = 4'b0001;
    repeat (7) step();
    refresh_a = 1'b1;
    step();
    refresh_a = 1'b0;
    count_a = '0;
    read_a(0, v, s);
    check("coincident old interval", 32'(v), 7);
    pulse_refresh_a();
    read_a(0, v, s);
    check("coincident new interval", 32'(v), 1);

    // Saturation with prescale on B: 70 events saturate a 6-bit counter
    do_reset();
    count_b = 2'b01;
    repeat (70) step();
    count_b = '0;
    refresh_b = 1'b1;
    step();
    refresh_b = 1'b0;
    addr_b = 1'b0;
    step();
    check("sat scaler", 32'(scaler_b), 15);
    check("sat flag", 32'(sat_b), 1);
    count_b = 2'b01;
    repeat (5) step();
    count_b = '0;
    refresh_b = 1'b1;
    step();
    refresh_b = 1'b0;
    step();
    check("prescale truncation", 32'(scaler_b), 1);
    check("sat cleared", 32'(sat_b), 0);
    addr_b = 1'b1;
    step();
    check("idle channel b1", 32'(scaler_b), 0);

    // Internal timer on C with continuous counting on channel 2
    do_reset();
    count_c = 4'b0100;
    wait_valid_c("timer first", cyc);
    addr_c = 2'd2;
    for (int n = 0; n < 4; n++) begin
      step();
      if (n > 0) check($sformatf("timer snap%0d", n), 32'(scaler_c), (n == 3) ? 32'd70 : 32'd100);
      check($sformatf("timer valid%0d one cycle", n), 32'(valid_c), 0);
      extra = 0;
      if (n == 2) begin
        repeat (10) step();
        gate = 1'b0;
        repeat (30) step();
        gate = 1'b1;
        extra = 40;
      end
      if (n < 3) begin
        wait_valid_c($sformatf("timer tick%0d", n), cyc);
        check($sformatf("timer period%0d", n), 32'(cyc + 1 + extra), 100);
      end
    end
    count_c = '0;

    // Asynchronous reset mid-interval on A
    do_reset();
    count_a = 4'b0001;
    repeat (5) step();
    count_a = '0;
    pulse_refresh_a();
    read_a(0, v, s);
    check("pre-reset read", 32'(v), 5);
    count_a = 4'b0001;
    repeat (50) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset scaler", 32'(scaler_a), 0);
    check("async reset seq", 32'(seq_a), 0);
    check("async reset valid", 32'(valid_a), 0);
    count_a = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    read_a(0, v, s);
    check("post-reset snapshot", 32'(v), 0);
    count_a = 4'b0001;
    repeat (3) step();
    count_a = '0;
    pulse_refresh_a();
    check("post-reset seq", 32'(seq_a), 1);
    read_a(0, v, s);
    check("post-reset count", 32'(v), 3);

    // Randomized run on A and B against the interval-count model
    do_reset();
    for (int i = 0; i < 4; i++) begin ca[i] = 0; pa[i] = 0; sva[i] = 0; ssa[i] = 0; end
    for (int i = 0; i < 2; i++) begin cb[i] = 0; pb[i] = 0; svb[i] = 0; ssb[i] = 0; end
    seq_m = '0;
    for (int t = 0; t < 600; t++) begin
      count_a = 4'($urandom);
      for (int i = 0; i < 2; i++) count_b[i] = ($urandom_range(0, 3) != 0);
      gate = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) edge_mode = ~edge_mode;
      refr = ($urandom_range(0, 47) == 0) || (refresh_a && $urandom_range(0, 1) == 0);
      refresh_a = refr;
      refresh_b = refr;
      addr_a = 3'($urandom_range(0, 7));
      addr_b = 1'($urandom_range(0, 1));

      exp_va = (addr_a < 4) ? sva[addr_a] : 0;
      exp_sa = (addr_a < 4) ? ssa[addr_a] : 1'b0;
      exp_vb = svb[addr_b];
      exp_sb = ssb[addr_b];

      for (int i = 0; i < 4; i++) begin
        ev = gate && (edge_mode ? (count_a[i] && !pa[i]) : count_a[i]);
        if (refr) begin
          sva[i] = (ca[i] > 65535) ? 65535 : ca[i];
          ssa[i] = (ca[i] > 65535);
          ca[i]  = int'(ev);
        end else begin
          ca[i] += int'(ev);
        end
        pa[i] = count_a[i];
      end
      for (int i = 0; i < 2; i++) begin
        ev = gate && (edge_mode ? (count_b[i] && !pb[i]) : count_b[i]);
        if (refr) begin
          svb[i] = ((cb[i] > 63) ? 63 : cb[i]) / 4;
          ssb[i] = (cb[i] > 63);
          cb[i]  = int'(ev);
        end else begin
          cb[i] += int'(ev);
        end
        pb[i] = count_b[i];
      end
      if (refr) seq_m = seq_m + 8'd1;

      step();
      check("rand a scaler", 32'(scaler_a), 32'(exp_va));
      check("rand a sat", 32'(sat_a), 32'(exp_sa));
      check("rand a valid", 32'(valid_a), 32'(refr));
      check("rand a seq", 32'(seq_a), 32'(seq_m));
      check("rand b scaler", 32'(scaler_b), 32'(exp_vb));
      check("rand b sat", 32'(sat_b), 32'(exp_sb));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
